// File: rtl/l1d_arb_pkg.sv
`default_nettype none
// ============================================================================
// l1d_arb_pkg : arbiter state encoding and round-robin mask helper
// Rev 1.0
// ============================================================================
package l1d_arb_pkg;

  localparam int unsigned ARB_MAX_REQ = 32;

  typedef enum logic [1:0] {
    ARB_S_ARB  = 2'd0,
    ARB_S_HOLD = 2'd1,
    ARB_S_LOCK = 2'd2
  } l1d_arb_state_e;

  // Bits strictly above ptr and below n; an all-zero result means wrap to index 0.
  function automatic logic [ARB_MAX_REQ-1:0] rr_mask(input int unsigned ptr,
                                                     input int unsigned n);
    logic [ARB_MAX_REQ-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
      m[i] = (i > ptr) && (i < n);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
// priority_encoder : index of the lowest set request bit
// Rev 1.0
// ============================================================================
module priority_encoder #(
  parameter  int WIDTH = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    vld_o = |req_i;
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/l1d_rr_req_arbiter.sv
`default_nettype none
// ============================================================================
// l1d_rr_req_arbiter : round-robin valid/ready arbiter for one L1D pipe port
// Optional burst lock via L1D_ARB_LOCK_EN.                          Rev 1.0
// ============================================================================
module l1d_rr_req_arbiter
  import l1d_arb_pkg::*;
#(
  parameter  int REQ_NUM  = 4,
  parameter  int PLD_W    = 64,
  localparam int REQ_ID_W = $clog2(REQ_NUM)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_NUM-1:0]              req_vld_i,
  input  logic [REQ_NUM-1:0][PLD_W-1:0]   req_pld_i,
  output logic [REQ_NUM-1:0]              req_rdy_o,
  output logic                            gnt_vld_o,
  output logic [REQ_ID_W-1:0]             gnt_id_o,
  output logic [PLD_W-1:0]                gnt_pld_o,
`ifdef L1D_ARB_LOCK_EN
  input  logic [REQ_NUM-1:0]              lock_i,
`endif
  input  logic                            gnt_rdy_i
);

  l1d_arb_state_e        state_q, state_d;
  logic [REQ_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [REQ_ID_W-1:0]   hold_id_q, hold_id_d;

  logic [REQ_NUM-1:0]    rr_mask_w;
  logic [REQ_NUM-1:0]    masked_vld_w;
  logic                  m_vld_w, u_vld_w;
  logic [REQ_ID_W-1:0]   m_idx_w, u_idx_w;
  logic                  win_vld_w;
  logic [REQ_ID_W-1:0]   win_id_w;
  logic                  hs_w;

  assign rr_mask_w    = REQ_NUM'(rr_mask(32'(rr_ptr_q), 32'(REQ_NUM)));
  assign masked_vld_w = req_vld_i & rr_mask_w;

  priority_encoder #(.WIDTH(REQ_NUM)) u_pe_masked (
    .req_i (masked_vld_w),
    .vld_o (m_vld_w),
    .idx_o (m_idx_w)
  );

  priority_encoder #(.WIDTH(REQ_NUM)) u_pe_unmasked (
    .req_i (req_vld_i),
    .vld_o (u_vld_w),
    .idx_o (u_idx_w)
  );

  // Outside ARB the held requester owns the port; its valid alone drives gnt_vld.
  always_comb begin
    win_id_w  = m_vld_w ? m_idx_w : u_idx_w;
    win_vld_w = u_vld_w;
    if (state_q != ARB_S_ARB) begin
      win_id_w  = hold_id_q;
      win_vld_w = req_vld_i[hold_id_q];
    end
  end

  assign hs_w      = win_vld_w & gnt_rdy_i;
  assign gnt_vld_o = win_vld_w & ~rst;
  assign gnt_id_o  = gnt_vld_o ? win_id_w : '0;
  assign gnt_pld_o = gnt_vld_o ? req_pld_i[win_id_w] : '0;
  assign req_rdy_o = (hs_w && !rst) ? (REQ_NUM'(1) << win_id_w) : '0;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    hold_id_d = hold_id_q;
    case (state_q)
      ARB_S_ARB: begin
        if (win_vld_w) begin
          if (gnt_rdy_i) begin
            rr_ptr_d = win_id_w;
`ifdef L1D_ARB_LOCK_EN
            if (lock_i[win_id_w]) begin
              state_d   = ARB_S_LOCK;
              hold_id_d = win_id_w;
            end
`endif
          end else begin
            state_d   = ARB_S_HOLD;
            hold_id_d = win_id_w;
          end
        end
      end
      ARB_S_HOLD: begin
        // A held requester dropping valid is a protocol error; release without a beat.
        if (!win_vld_w) begin
          state_d = ARB_S_ARB;
        end else if (gnt_rdy_i) begin
          rr_ptr_d = hold_id_q;
          state_d  = ARB_S_ARB;
`ifdef L1D_ARB_LOCK_EN
          if (lock_i[hold_id_q]) state_d = ARB_S_LOCK;
`endif
        end
      end
`ifdef L1D_ARB_LOCK_EN
      ARB_S_LOCK: begin
        if (hs_w) begin
          rr_ptr_d = hold_id_q;
          if (!lock_i[hold_id_q]) state_d = ARB_S_ARB;
        end
      end
`endif
      default: state_d = ARB_S_ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_S_ARB;
      rr_ptr_q  <= REQ_ID_W'(REQ_NUM - 1);
      hold_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_id_q <= hold_id_d;
    end
  end

`ifndef SYNTHESIS
  a_rdy_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_rdy_o));

  a_gnt_stable: assert property (@(posedge clk) disable iff (rst)
    (gnt_vld_o && !gnt_rdy_i) |=> ($stable(gnt_id_o) && $stable(gnt_pld_o)));

  a_hold_vld: assert property (@(posedge clk) disable iff (rst)
    (state_q == ARB_S_HOLD) |-> req_vld_i[hold_id_q]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_l1d_rr_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_l1d_rr_req_arbiter : directed scoreboard bench for the round-robin arbiter
// Rev 1.0
// ============================================================================
module tb_l1d_rr_req_arbiter;

  localparam int REQ_NUM = 4;
  localparam int PLD_W   = 64;

  logic                          clk;
  logic                          rst;
  logic [REQ_NUM-1:0]            req_vld;
  logic [REQ_NUM-1:0][PLD_W-1:0] req_pld;
  logic [REQ_NUM-1:0]            req_rdy;
  logic                          gnt_vld;
  logic [1:0]                    gnt_id;
  logic [PLD_W-1:0]              gnt_pld;
  logic                          gnt_rdy;
`ifdef L1D_ARB_LOCK_EN
  logic [REQ_NUM-1:0]            lock;
`endif

  typedef struct {
    logic             vld;
    logic [1:0]       id;
    logic [PLD_W-1:0] pld;
    logic [3:0]       rdy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  l1d_rr_req_arbiter #(.REQ_NUM(REQ_NUM), .PLD_W(PLD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld_i (req_vld),
    .req_pld_i (req_pld),
    .req_rdy_o (req_rdy),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id),
    .gnt_pld_o (gnt_pld),
`ifdef L1D_ARB_LOCK_EN
    .lock_i    (lock),
`endif
    .gnt_rdy_i (gnt_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PLD_W-1:0] pld_of(input int i);
    return 64'hA5C3_0000_0000_0000 | (64'(i + 1) * 64'h0000_0101_0101_0101);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, queue the expected grant, compare at the falling edge.
  task automatic step(input logic [3:0] vld, input logic r, input logic x_vld,
                      input logic [1:0] x_id, input string tag);
    exp_t e;
    req_vld = vld;
    gnt_rdy = r;
    e.vld = x_vld & ~rst;
    e.id  = e.vld ? x_id : 2'd0;
    e.pld = e.vld ? pld_of(int'(x_id)) : '0;
    e.rdy = (e.vld && r) ? (4'b0001 << x_id) : 4'b0000;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".vld"}, 64'(gnt_vld), 64'(e.vld));
    chk({tag, ".id"},  64'(gnt_id),  64'(e.id));
    chk({tag, ".pld"}, gnt_pld,      e.pld);
    chk({tag, ".rdy"}, 64'(req_rdy), 64'(e.rdy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    req_vld = 4'b1111;
    gnt_rdy = 1'b1;
`ifdef L1D_ARB_LOCK_EN
    lock    = '0;
`endif
    for (int i = 0; i < REQ_NUM; i++) req_pld[i] = pld_of(i);
    @(posedge clk);
    #1;
    step(4'b1111, 1'b1, 1'b0, 2'd0, "rst");
    rst = 1'b0;

    // Full rotation with wrap
    step(4'b1111, 1'b1, 1'b1, 2'd0, "t1_0");
    step(4'b1111, 1'b1, 1'b1, 2'd1, "t1_1");
    step(4'b1111, 1'b1, 1'b1, 2'd2, "t1_2");
    step(4'b1111, 1'b1, 1'b1, 2'd3, "t1_3");
    step(4'b1111, 1'b1, 1'b1, 2'd0, "t1_wrap");

    // Pointer at 1, sparse requests
    step(4'b1111, 1'b1, 1'b1, 2'd1, "t2_ptr1");
    step(4'b0101, 1'b1, 1'b1, 2'd2, "t2_a");
    step(4'b0101, 1'b1, 1'b1, 2'd0, "t2_b");

    // Lone requester wins back-to-back
    step(4'b0100, 1'b1, 1'b1, 2'd2, "single0");
    step(4'b0100, 1'b1, 1'b1, 2'd2, "single1");
    step(4'b0100, 1'b1, 1'b1, 2'd2, "single2");

    // Backpressure hold with a late higher-priority request
    step(4'b1000, 1'b1, 1'b1, 2'd3, "t3_ptr3");
    step(4'b0011, 1'b0, 1'b1, 2'd0, "t3_stall0");
    step(4'b1011, 1'b0, 1'b1, 2'd0, "t3_stall1");
    step(4'b1011, 1'b0, 1'b1, 2'd0, "t3_stall2");
    step(4'b1011, 1'b1, 1'b1, 2'd0, "t3_hs");
    step(4'b1011, 1'b1, 1'b1, 2'd1, "t3_next");

    // Idle keeps pointer
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b1, 1'b0, 2'd0, "t6_idle");
    step(4'b1111, 1'b1, 1'b1, 2'd2, "t6_ptr");

`ifdef L1D_ARB_LOCK_EN
    step(4'b1000, 1'b1, 1'b1, 2'd3, "t4_ptr3");
    lock = 4'b0001;
    step(4'b0011, 1'b1, 1'b1, 2'd0, "t4_lk0");
    step(4'b0011, 1'b1, 1'b1, 2'd0, "t4_lk1");
    step(4'b0011, 1'b1, 1'b1, 2'd0, "t4_lk2");
    lock = 4'b0000;
    step(4'b0011, 1'b1, 1'b1, 2'd0, "t4_last");
    step(4'b0011, 1'b1, 1'b1, 2'd1, "t4_next");
`endif

    // Reset while holding
    step(4'b1000, 1'b0, 1'b1, 2'd3, "t5_stall");
    rst = 1'b1;
    step(4'b1000, 1'b0, 1'b0, 2'd0, "t5_rst0");
    step(4'b1000, 1'b1, 1'b0, 2'd0, "t5_rst1");
    rst = 1'b0;
    step(4'b1100, 1'b1, 1'b1, 2'd2, "t5_ptr_rst");
    step(4'b1000, 1'b1, 1'b1, 2'd3, "t5_id3");
    step(4'b1001, 1'b1, 1'b1, 2'd0, "t5_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
